// File: rtl/aes_pkg.sv
// Shared AES-128 key schedule definitions:
// widths, round count, Rcon, S-box and FSM states.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } ks_state_e;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*(255 - int'(x)) +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  // Rounds past the table contribute no constant.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    if (r <= 4'd9) v = RCON[r];
    return v;
  endfunction

endpackage

// File: rtl/key_expansion.sv
// One AES-128 key schedule round: derives the
// next round key from the current one.
module key_expansion
  import aes_pkg::*;
(
  input  logic [3:0]       num_round,
  input  logic [KEY_W-1:0] input_key,
  output logic [KEY_W-1:0] output_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  // RotWord/SubWord/Rcon on word 3, then chained XOR.
  always_comb begin
    w0 = input_key[127:96];
    w1 = input_key[95:64];
    w2 = input_key[63:32];
    w3 = input_key[31:0];
    t  = sub_word({w3[23:0], w3[31:24]})
       ^ {rcon_of(num_round), 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    output_key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key expansion controller with
// a register file of round keys read combinationally.
module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] LAST_SLOT = 4'(NUM_ROUNDS);

  ks_state_e    state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;
  logic         kv_q, kv_d;
  logic [127:0] slot_q [NUM_ROUNDS+1];
  logic [127:0] slot_d [NUM_ROUNDS+1];
  logic [127:0] next_key;

  key_expansion u_kexp (
    .num_round  (rnd_q),
    .input_key  (slot_q[rnd_q]),
    .output_key (next_key)
  );

  // Next state: capture key in IDLE, one round per cycle in EXPAND.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          slot_d[0] = key_in;
          rnd_d     = 4'd0;
          kv_d      = 1'b0;
          state_d   = EXPAND;
        end
      end
      EXPAND: begin
        slot_d[rnd_q + 4'd1] = next_key;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          state_d = IDLE;
          rnd_d   = 4'd0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end
      end
    endcase
  end

  // State and slot registers; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
      slot_q  <= slot_d;
    end
  end

  assign busy       = (state_q == EXPAND);
  assign done       = done_q;
  assign keys_valid = kv_q;

  // Combinational slot read; out-of-range addresses read zero.
  always_comb begin
    rd_key = '0;
    if (rd_addr <= LAST_SLOT) rd_key = slot_q[rd_addr];
  end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10: number of AES-128 round keys generated after the cipher key.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to expand key_in; sampled only in IDLE.
REQ-005 key_in  input  128  cipher key, word 0 in bits [127:96].
REQ-006 busy  output  1  high while expansion is in progress.
REQ-007 done  output  1  one-cycle pulse when the final round key is stored.
REQ-008 keys_valid  output  1  high while slots 0..NUM_ROUNDS hold keys of the last accepted key_in.
REQ-009 rd_addr  input  4  round-key slot select, 0..NUM_ROUNDS.
REQ-010 rd_key  output  128  round key at rd_addr.

Function
REQ-011 The FSM SHALL have exactly the states IDLE and EXPAND.
REQ-012 In IDLE with start=1 at an edge: slot0<=key_in; rnd<=0; keys_valid<=0; state<=EXPAND.
REQ-013 In EXPAND at each edge: slot[rnd+1]<=round_fn(num_round=rnd, input_key=slot[rnd]); rnd<=rnd+1.
REQ-014 round_fn: RotWord+SubWord of word 3, XOR Rcon(rnd) into word 0, chained XOR for words 1..3; Rcon(0..9)=01,02,04,08,10,20,40,80,1b,36 in the MSB.
REQ-015 When an edge writes slot NUM_ROUNDS: state<=IDLE; done=1 for the following cycle only; keys_valid<=1.
REQ-016 busy SHALL equal (state==EXPAND); busy is high for exactly NUM_ROUNDS cycles per accepted start.
REQ-017 Latency: start sampled at edge T -> done high in the cycle following edge T+NUM_ROUNDS.
REQ-018 start while busy SHALL be ignored and SHALL NOT alter rnd, slots or key_in capture.
REQ-019 start in the done cycle (state IDLE) SHALL be accepted as a new request; keys_valid falls at that edge.
REQ-020 key_in SHALL be sampled only at the accepting edge; later changes have no effect.
REQ-021 rd_key SHALL be a combinational read of slot[rd_addr]; rd_addr>NUM_ROUNDS returns 128'h0.
REQ-022 Reads during EXPAND SHALL return current slot contents; consumers gate on keys_valid.
REQ-023 rnd SHALL be 4 bits and never exceed NUM_ROUNDS-1 while in EXPAND.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, rnd=0, busy=0, done=0, keys_valid=0, all slots=0.
REQ-025 rst asserted mid-expansion SHALL abort it; no done pulse follows; first start after rst deassertion begins a fresh expansion.

Structure
REQ-026 Shared package aes_pkg SHALL hold NUM_ROUNDS, the key width (128), the Rcon table and the FSM state enum.
REQ-027 The per-round transform SHALL be one instance of the existing single-round key_expansion sub-module, driven from slot[rnd] and rnd.
REQ-028 Slot storage SHALL be registers (11 x 128), not inferred RAM, so that rd_key stays combinational.

Verification
REQ-029 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> done 10 cycles later; slot1=a0fafe1788542cb123a339392a6c7605, slot10=d014f9a8c9ee2589e13f0cc8b6630ca6, slot0=key.
REQ-030 Start held high for 15 cycles -> exactly one expansion, then a second accepted on the cycle after done; done pulses exactly twice.
REQ-031 rst pulsed at busy cycle 5 -> outputs and slots zero, no done; restart with key 000102030405060708090a0b0c0d0e0f -> slot10=13111d7fe3944a17f307a78b4d2b30c5.
REQ-032 key_in changed every cycle during EXPAND -> slot contents match the key captured at the start edge.
REQ-033 rd_addr sweep 0..15 after done -> slots 0..10 match the golden model; addresses 11..15 read 0.
